// File: rtl/mips_multicycle_control.sv
// mips_multicycle_control: Moore FSM sequencing the multi-cycle MIPS datapath with a retired-instruction counter
module mips_multicycle_control #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             ir_write,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             illegal_op,
  output logic             instr_retired,
  output logic [CNT_W-1:0] retired_count,
  output logic [3:0]       state
);
  typedef enum logic [3:0] {
    FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, EXECUTE,
    ALU_WB, BRANCH, JUMP, ADDI_EX, ADDI_WB, TRAP
  } state_t;
  state_t st, nxt;
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      st  <= FETCH;
      cnt <= '0;
    end else begin
      st  <= nxt;
      cnt <= cnt + CNT_W'(instr_retired);
    end
  end
  always_comb begin
    nxt = FETCH;
    case (st)
      FETCH:     nxt = mem_ready ? DECODE : FETCH;
      DECODE:    nxt = opcode == 6'b000000 ? EXECUTE :
                       (opcode == 6'b100011 || opcode == 6'b101011) ? MEM_ADDR :
                       opcode == 6'b000100 ? BRANCH :
                       opcode == 6'b000010 ? JUMP :
                       opcode == 6'b001000 ? ADDI_EX : TRAP;
      MEM_ADDR:  nxt = opcode == 6'b100011 ? MEM_READ : MEM_WRITE;
      MEM_READ:  nxt = mem_ready ? MEM_WB : MEM_READ;
      MEM_WRITE: nxt = mem_ready ? FETCH : MEM_WRITE;
      EXECUTE:   nxt = ALU_WB;
      ADDI_EX:   nxt = ADDI_WB;
      default:   nxt = FETCH;
    endcase
  end
  // Reset overrides every output, including the ones that follow live inputs.
  always_comb begin
    {pc_write, pc_src, ir_write, iord, mem_read, mem_write, mem_to_reg,
     reg_write, reg_dst, alu_src_a, alu_src_b, alu_op, illegal_op} = '0;
    if (!rst) case (st)
      FETCH:     begin mem_read = 1'b1; alu_src_b = 2'b01; ir_write = mem_ready; pc_write = mem_ready; end
      DECODE:    alu_src_b = 2'b11;
      MEM_ADDR:  begin alu_src_a = 1'b1; alu_src_b = 2'b10; end
      MEM_READ:  begin mem_read = 1'b1; iord = 1'b1; end
      MEM_WB:    begin reg_write = 1'b1; mem_to_reg = 1'b1; end
      MEM_WRITE: begin mem_write = 1'b1; iord = 1'b1; end
      EXECUTE:   begin alu_src_a = 1'b1; alu_op = 2'b10; end
      ALU_WB:    begin reg_write = 1'b1; reg_dst = 1'b1; end
      BRANCH:    begin alu_src_a = 1'b1; alu_op = 2'b01; pc_src = 2'b01; pc_write = zero; end
      JUMP:      begin pc_src = 2'b10; pc_write = 1'b1; end
      ADDI_EX:   begin alu_src_a = 1'b1; alu_src_b = 2'b10; end
      ADDI_WB:   reg_write = 1'b1;
      TRAP:      illegal_op = 1'b1;
      default:   ;
    endcase
  end
  assign instr_retired = !rst && (st == MEM_WB || st == ALU_WB || st == BRANCH ||
                                  st == JUMP || st == ADDI_WB || (st == MEM_WRITE && mem_ready));
  assign retired_count = rst ? '0 : cnt;
  assign state         = rst ? 4'd0 : st;
endmodule

// File: tb/tb_mips_multicycle_control.sv
// tb_mips_multicycle_control: directed per-cycle vectors pushed to a scoreboard, checked by a negedge monitor
module tb_mips_multicycle_control;
  logic clk = 1'b0, rst = 1'b1, zero = 1'b0, mem_ready = 1'b0;
  logic [5:0] opcode = '0;
  logic pc_write, ir_write, iord, mem_read, mem_write, mem_to_reg, reg_write, reg_dst, alu_src_a;
  logic illegal_op, instr_retired;
  logic [1:0] pc_src, alu_src_b, alu_op;
  logic [3:0] retired_count, state;
  int checks = 0, errors = 0;
  logic [3:0] cnt = '0;

  typedef struct {string name; logic [3:0] st; logic [16:0] ctl; logic [3:0] cnt;} exp_t;
  exp_t q[$];
  exp_t e;

  mips_multicycle_control #(.CNT_W(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .reg_dst(reg_dst), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .illegal_op(illegal_op),
    .instr_retired(instr_retired), .retired_count(retired_count), .state(state)
  );

  always #5 clk = ~clk;

  function automatic logic [16:0] ctl(logic pw, logic [1:0] ps, logic irw, logic ia, logic mr,
                                      logic mw, logic m2r, logic rw, logic rd, logic asa,
                                      logic [1:0] asb, logic [1:0] aop, logic ill, logic ret);
    return {pw, ps, irw, ia, mr, mw, m2r, rw, rd, asa, asb, aop, ill, ret};
  endfunction

  //                                     pw ps    irw ia mr mw m2r rw rd asa asb    aop   ill ret
  localparam logic [16:0] E_ZERO    = ctl(0, 2'd0, 0, 0, 0, 0, 0,  0, 0, 0, 2'd0, 2'd0, 0, 0);
  localparam logic [16:0] E_FETCH_W = ctl(0, 2'd0, 0, 0, 1, 0, 0,  0, 0, 0, 2'd1, 2'd0, 0, 0);
  localparam logic [16:0] E_FETCH_R = ctl(1, 2'd0, 1, 0, 1, 0, 0,  0, 0, 0, 2'd1, 2'd0, 0, 0);
  localparam logic [16:0] E_DEC     = ctl(0, 2'd0, 0, 0, 0, 0, 0,  0, 0, 0, 2'd3, 2'd0, 0, 0);
  localparam logic [16:0] E_MADDR   = ctl(0, 2'd0, 0, 0, 0, 0, 0,  0, 0, 1, 2'd2, 2'd0, 0, 0);
  localparam logic [16:0] E_MREAD   = ctl(0, 2'd0, 0, 1, 1, 0, 0,  0, 0, 0, 2'd0, 2'd0, 0, 0);
  localparam logic [16:0] E_MWB     = ctl(0, 2'd0, 0, 0, 0, 0, 1,  1, 0, 0, 2'd0, 2'd0, 0, 1);
  localparam logic [16:0] E_MWR_W   = ctl(0, 2'd0, 0, 1, 0, 1, 0,  0, 0, 0, 2'd0, 2'd0, 0, 0);
  localparam logic [16:0] E_MWR_R   = ctl(0, 2'd0, 0, 1, 0, 1, 0,  0, 0, 0, 2'd0, 2'd0, 0, 1);
  localparam logic [16:0] E_EXE     = ctl(0, 2'd0, 0, 0, 0, 0, 0,  0, 0, 1, 2'd0, 2'd2, 0, 0);
  localparam logic [16:0] E_AWB     = ctl(0, 2'd0, 0, 0, 0, 0, 0,  1, 1, 0, 2'd0, 2'd0, 0, 1);
  localparam logic [16:0] E_BR1     = ctl(1, 2'd1, 0, 0, 0, 0, 0,  0, 0, 1, 2'd0, 2'd1, 0, 1);
  localparam logic [16:0] E_BR0     = ctl(0, 2'd1, 0, 0, 0, 0, 0,  0, 0, 1, 2'd0, 2'd1, 0, 1);
  localparam logic [16:0] E_JMP     = ctl(1, 2'd2, 0, 0, 0, 0, 0,  0, 0, 0, 2'd0, 2'd0, 0, 1);
  localparam logic [16:0] E_AEX     = ctl(0, 2'd0, 0, 0, 0, 0, 0,  0, 0, 1, 2'd2, 2'd0, 0, 0);
  localparam logic [16:0] E_AWBI    = ctl(0, 2'd0, 0, 0, 0, 0, 0,  1, 0, 0, 2'd0, 2'd0, 0, 1);
  localparam logic [16:0] E_TRAP    = ctl(0, 2'd0, 0, 0, 0, 0, 0,  0, 0, 0, 2'd0, 2'd0, 1, 0);

  task automatic step(input string n, input logic r, input logic [5:0] op, input logic z,
                      input logic mr, input logic [3:0] es, input logic [16:0] ec);
    rst = r; opcode = op; zero = z; mem_ready = mr;
    if (r) cnt = '0;
    q.push_back('{n, es, ec, cnt});
    if (!r && ec[0]) cnt = cnt + 4'd1;
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      e = q.pop_front();
      checks += 3;
      if (state !== e.st) begin
        errors++;
        $display("FAIL %s state got %0d want %0d", e.name, state, e.st);
      end
      if ({pc_write, pc_src, ir_write, iord, mem_read, mem_write, mem_to_reg, reg_write, reg_dst,
           alu_src_a, alu_src_b, alu_op, illegal_op, instr_retired} !== e.ctl) begin
        errors++;
        $display("FAIL %s ctl got %05h want %05h", e.name,
                 {pc_write, pc_src, ir_write, iord, mem_read, mem_write, mem_to_reg, reg_write, reg_dst,
                  alu_src_a, alu_src_b, alu_op, illegal_op, instr_retired}, e.ctl);
      end
      if (retired_count !== e.cnt) begin
        errors++;
        $display("FAIL %s count got %0d want %0d", e.name, retired_count, e.cnt);
      end
    end
  end

  initial begin
    @(posedge clk); #1;
    step("reset",   1, 6'h00, 0, 0, 4'd0,  E_ZERO);
    step("fwait1",  0, 6'h00, 0, 0, 4'd0,  E_FETCH_W);
    step("fwait2",  0, 6'h00, 0, 0, 4'd0,  E_FETCH_W);
    step("fwait3",  0, 6'h00, 0, 0, 4'd0,  E_FETCH_W);
    step("r_fetch", 0, 6'h00, 0, 1, 4'd0,  E_FETCH_R);
    step("r_dec",   0, 6'h00, 0, 1, 4'd1,  E_DEC);
    step("r_exe",   0, 6'h00, 0, 1, 4'd6,  E_EXE);
    step("r_wb",    0, 6'h00, 0, 1, 4'd7,  E_AWB);
    step("lw_f",    0, 6'h23, 0, 1, 4'd0,  E_FETCH_R);
    step("lw_d",    0, 6'h23, 0, 1, 4'd1,  E_DEC);
    step("lw_a",    0, 6'h23, 0, 1, 4'd2,  E_MADDR);
    step("lw_r",    0, 6'h23, 0, 1, 4'd3,  E_MREAD);
    step("lw_wb",   0, 6'h23, 0, 1, 4'd4,  E_MWB);
    step("sw_f",    0, 6'h2b, 0, 1, 4'd0,  E_FETCH_R);
    step("sw_d",    0, 6'h2b, 0, 1, 4'd1,  E_DEC);
    step("sw_a",    0, 6'h2b, 0, 1, 4'd2,  E_MADDR);
    step("sw_wait", 0, 6'h2b, 0, 0, 4'd5,  E_MWR_W);
    step("sw_w",    0, 6'h2b, 0, 1, 4'd5,  E_MWR_R);
    step("ai_f",    0, 6'h08, 0, 1, 4'd0,  E_FETCH_R);
    step("ai_d",    0, 6'h08, 0, 1, 4'd1,  E_DEC);
    step("ai_ex",   0, 6'h08, 0, 0, 4'd10, E_AEX);
    step("ai_wb",   0, 6'h08, 0, 0, 4'd11, E_AWBI);
    step("bq1_f",   0, 6'h04, 1, 1, 4'd0,  E_FETCH_R);
    step("bq1_d",   0, 6'h04, 1, 1, 4'd1,  E_DEC);
    step("bq1_b",   0, 6'h04, 1, 1, 4'd8,  E_BR1);
    step("bq0_f",   0, 6'h04, 0, 1, 4'd0,  E_FETCH_R);
    step("bq0_d",   0, 6'h04, 0, 1, 4'd1,  E_DEC);
    step("bq0_b",   0, 6'h04, 0, 1, 4'd8,  E_BR0);
    step("ill_f",   0, 6'h3f, 0, 1, 4'd0,  E_FETCH_R);
    step("ill_d",   0, 6'h3f, 0, 1, 4'd1,  E_DEC);
    step("ill_t",   0, 6'h3f, 0, 1, 4'd12, E_TRAP);
    step("mr_f",    0, 6'h23, 0, 1, 4'd0,  E_FETCH_R);
    step("mr_d",    0, 6'h23, 0, 1, 4'd1,  E_DEC);
    step("mr_a",    0, 6'h23, 0, 1, 4'd2,  E_MADDR);
    step("mr_w1",   0, 6'h23, 0, 0, 4'd3,  E_MREAD);
    step("mr_w2",   0, 6'h23, 0, 0, 4'd3,  E_MREAD);
    step("mr_rst",  1, 6'h23, 0, 0, 4'd0,  E_ZERO);
    for (int i = 0; i < 17; i++) begin
      step($sformatf("j%0d_f", i), 0, 6'h02, 0, 1, 4'd0, E_FETCH_R);
      step($sformatf("j%0d_d", i), 0, 6'h02, 0, 1, 4'd1, E_DEC);
      step($sformatf("j%0d_j", i), 0, 6'h02, 0, 1, 4'd9, E_JMP);
    end
    step("wrap",    0, 6'h00, 0, 0, 4'd0,  E_FETCH_W);
    @(negedge clk); #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain pending got %0d want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mips_multicycle_control.md
Name: mips_multicycle_control

Overview:
- Moore FSM that sequences the multi-cycle MIPS datapath: fetch, decode, execute, memory and writeback for each instruction.
- Consumes the 6-bit opcode field from the instruction decoder and the ALU zero flag.
- Drives all datapath strobes and muxes, handshakes with the unified instruction/data memory, and counts retired instructions.
- Any unsupported opcode traps and is skipped.

Parameters:
- CNT_W, 16, width of the retired-instruction counter; wraps modulo 2^CNT_W.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- opcode  in  6  instr[31:26] from the instruction decoder
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory has completed the current read/write this cycle
- pc_write  out  1  PC load enable
- pc_src  out  2  00 = ALU result, 01 = ALUOut (branch target), 10 = jump address
- ir_write  out  1  instruction register load
- iord  out  1  memory address: 0 = PC, 1 = ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- mem_to_reg  out  1  register write data: 1 = MDR, 0 = ALUOut
- reg_write  out  1  register file write enable
- reg_dst  out  1  destination register: 1 = rd, 0 = rt
- alu_src_a  out  1  ALU A input: 0 = PC, 1 = reg A
- alu_src_b  out  2  ALU B input: 00 = reg B, 01 = const 4, 10 = sign-extended imm, 11 = sign-extended imm<<2
- alu_op  out  2  00 = add, 01 = subtract, 10 = use funct
- illegal_op  out  1  one-cycle pulse on unsupported opcode
- instr_retired  out  1  one-cycle pulse when an instruction completes
- retired_count  out  CNT_W  count of retired instructions
- state  out  4  current state encoding (debug)

Behaviour:
- States and encodings: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXECUTE=6, ALU_WB=7, BRANCH=8, JUMP=9, ADDI_EX=10, ADDI_WB=11, TRAP=12. Encodings 13–15 go to FETCH.
- Reset: while rst=1, state<=FETCH, retired_count<=0, and every output is forced to 0 (including state=0). This applies in any state, including mid memory wait. The first cycle after rst falls is FETCH.
- Default value of every output in every state is 0. Only the values listed below are asserted.
- FETCH:
  - Asserts mem_read=1, iord=0, alu_src_b=01, alu_op=00.
  - ir_write and pc_write equal mem_ready.
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE:
  - Asserts alu_src_b=11, alu_op=00.
  - Next state by opcode: 000000 -> EXECUTE; 100011 (lw) or 101011 (sw) -> MEM_ADDR; 000100 (beq) -> BRANCH; 000010 (j) -> JUMP; 001000 (addi) -> ADDI_EX; any other opcode -> TRAP.
- MEM_ADDR:
  - Asserts alu_src_a=1, alu_src_b=10, alu_op=00.
  - Goes to MEM_READ if opcode=100011, otherwise MEM_WRITE.
- MEM_READ: asserts mem_read=1, iord=1. Holds until mem_ready=1, then goes to MEM_WB.
- MEM_WB: asserts reg_write=1, mem_to_reg=1, reg_dst=0. Retires; goes to FETCH.
- MEM_WRITE: asserts mem_write=1, iord=1. Holds until mem_ready=1; in that cycle it retires and goes to FETCH.
- EXECUTE: asserts alu_src_a=1, alu_src_b=00, alu_op=10. Goes to ALU_WB.
- ALU_WB: asserts reg_write=1, reg_dst=1. Retires; goes to FETCH.
- BRANCH:
  - Asserts alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01.
  - pc_write equals zero (combinational).
  - Retires; goes to FETCH.
- JUMP: asserts pc_src=10, pc_write=1. Retires; goes to FETCH.
- ADDI_EX: asserts alu_src_a=1, alu_src_b=10, alu_op=00. Goes to ADDI_WB.
- ADDI_WB: asserts reg_write=1, reg_dst=0, mem_to_reg=0. Retires; goes to FETCH.
- TRAP: illegal_op=1 for exactly one cycle. No retire, no pc_write. Goes to FETCH.
- Opcode stability: the opcode input is only sampled in DECODE and MEM_ADDR. The datapath holds IR stable from the FETCH load onward.
- Retire:
  - instr_retired is combinational and high in the retiring cycle.
  - retired_count increments on the same edge.
  - At all-ones, retired_count wraps to 0 with no flag.
- Memory handshake:
  - mem_read/mem_write stay asserted continuously until the cycle mem_ready=1.
  - mem_ready is ignored in all other states.
- Latency with mem_ready tied high, FETCH entry to next FETCH entry:
  - lw 5 cycles
  - sw 4
  - R-type 4
  - addi 4
  - beq 3
  - j 3
  - illegal 3

Test Plan:
- Reset mid MEM_READ with mem_ready=0: assert rst for 1 cycle -> all outputs 0, retired_count=0; next cycle state=0 with mem_read=1.
- mem_ready=1 constant; sequence opcodes 000000, 100011, 101011, 001000 -> state traces 0,1,6,7 / 0,1,2,3,4 / 0,1,2,5 / 0,1,10,11; retired_count=4; reg_write asserted only in states 7, 4, 11.
- beq (000100) with zero=1 then with zero=0 -> state 8 shows pc_write=1, pc_src=01 in the first case, pc_write=0 in the second; instr_retired pulses both times.
- FETCH with mem_ready low for 3 cycles -> state stays 0, mem_read held 1, ir_write/pc_write 0; on the 4th cycle mem_ready=1 -> ir_write=pc_write=1, then state 1.
- Opcode 111111 -> states 0,1,12,0; illegal_op high exactly 1 cycle; retired_count unchanged.
- CNT_W=4; retire 17 jumps (000010) -> retired_count=1 after wrap; each jump shows pc_src=10, pc_write=1 in state 9.
